urv_pipe_ctrl: RTL and testbench
================================

URV_PIPE_CTRL -- requirements
Module: urv_pipe_ctrl

Interface
REQ-001 Parameter g_num_stages, default 4: number of pipeline stages, index 0 = fetch, g_num_stages-1 = writeback; legal range 3..8.
REQ-002 Parameter g_branch_stage, default 2: stage index that resolves branches and traps; legal range 1..g_num_stages-2.
REQ-003 Parameter g_cnt_width, default 32: width of the stall-cycle performance counter.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 stall_req_i  in  g_num_stages  per-stage stall request; bit s from stage s.
REQ-007 stage_valid_i  in  g_num_stages  per-stage "holds valid instruction" flag.
REQ-008 branch_take_i  in  1  branch taken in stage g_branch_stage this cycle.
REQ-009 flush_i  in  1  trap/interrupt redirect from stage g_branch_stage this cycle.
REQ-010 halt_req_i  in  1  debug halt request, level.
REQ-011 resume_i  in  1  debug resume, single-cycle pulse.
REQ-012 stall_o  out  g_num_stages  per-stage stall.
REQ-013 kill_o  out  g_num_stages  per-stage kill (invalidate instruction).
REQ-014 halted_o  out  1  core halted.
REQ-015 stall_cnt_o  out  g_cnt_width  count of cycles with stall_o[0] high.

Function
REQ-016 Redirect event: redir = branch_take_i | flush_i (simultaneous assertion = one event).
REQ-017 Shift register bra_q[g_branch_stage-1:0]: when stall_o[g_branch_stage]=0, bra_q[0] <= redir, bra_q[k] <= bra_q[k-1]; else hold.
REQ-018 kill_o[0] = redir; kill_o[s] for 1<=s<=g_branch_stage = redir | (OR of bra_q[0..s-1]); kill_o[s] = 0 for s > g_branch_stage; combinational.
REQ-019 Base stall: stall_o[s] = OR of stall_req_i[j] for j > s; stall_o[g_num_stages-1] always 0 in RUN.
REQ-020 FSM states RUN, DRAIN, HALTED.
REQ-021 RUN -> DRAIN when halt_req_i=1; DRAIN: stall_o[0] forced 1, other stages per REQ-019.
REQ-022 DRAIN -> HALTED when stage_valid_i[g_num_stages-1:1] = 0 and bra_q = 0; while draining, redirects still tracked and killed normally.
REQ-023 HALTED: stall_o all ones, kill_o all zero, halted_o = 1 (registered, asserted first cycle in HALTED).
REQ-024 HALTED -> RUN on resume_i; halted_o low the cycle after resume_i; resume_i ignored outside HALTED.
REQ-025 halt_req_i deasserted during DRAIN: return to RUN next cycle, no halted_o pulse.
REQ-026 stall_cnt_o increments by 1 each cycle stall_o[0]=1 in RUN or DRAIN; not in HALTED; saturates at all-ones, no wrap.

Reset
REQ-027 rst_n_i low asynchronously forces: bra_q = 0, state RUN, halted_o = 0, stall_cnt_o = 0.
REQ-028 During reset, kill_o and stall_o follow combinational inputs with cleared state; reset mid-drain or mid-halt returns to RUN, no resume needed.

Structure
REQ-029 FSM state encoding and stage-index constants (fetch, decode, execute, writeback) reside in shared urv_defs include file.
REQ-030 Single flat module; bra_q shift-register tracker is the only natural sub-block, optional sub-module urv_redir_tracker.

Verification (g_num_stages=4, g_branch_stage=2)
REQ-031 branch_take_i pulse, no stalls -> kill_o = 4'b0111 cycle 0, 4'b0110 cycle 1, 4'b0100 cycle 2, 0 after.
REQ-032 stall_req_i = 4'b1000 for 3 cycles after branch -> kill_o held 4'b0110 for 3 cycles, then sequence continues; stall_o = 4'b0111.
REQ-033 branch_take_i and flush_i same cycle -> identical to single event in REQ-031.
REQ-034 halt_req_i=1, stage_valid_i clears 3 cycles later -> DRAIN 3 cycles, stall_o[0]=1, halted_o=1 next cycle, stall_o=4'b1111; resume_i -> RUN, halted_o=0.
REQ-035 Preload stall_cnt_o near max (g_cnt_width=4, 20 stall cycles) -> saturates at 4'hF.
REQ-036 rst_n_i low while HALTED, asynchronous to clk_i -> halted_o=0 immediately, state RUN after release.

Source files
------------

// File: rtl/urv_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and stage indices.
package urv_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } pipe_state_e;

  localparam int unsigned StageFetch   = 0;
  localparam int unsigned StageDecode  = 1;
  localparam int unsigned StageExecute = 2;

  // Writeback is always the last stage, so its index depends on pipeline depth.
  function automatic int unsigned stage_writeback(int unsigned num_stages);
    return num_stages - 1;
  endfunction

endpackage

// File: rtl/urv_pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the pipeline controller.
interface urv_pipe_ctrl_if #(
  parameter int unsigned NumStages = 4,
  parameter int unsigned CntWidth  = 32
);

  logic [NumStages-1:0] stall_req_i;
  logic [NumStages-1:0] stage_valid_i;
  logic                 branch_take_i;
  logic                 flush_i;
  logic                 halt_req_i;
  logic                 resume_i;
  logic [NumStages-1:0] stall_o;
  logic [NumStages-1:0] kill_o;
  logic                 halted_o;
  logic [CntWidth-1:0]  stall_cnt_o;

  // Pipeline / debug side: drives requests, observes control.
  modport master (
    output stall_req_i, stage_valid_i, branch_take_i, flush_i, halt_req_i, resume_i,
    input  stall_o, kill_o, halted_o, stall_cnt_o
  );

  // Controller side.
  modport slave (
    input  stall_req_i, stage_valid_i, branch_take_i, flush_i, halt_req_i, resume_i,
    output stall_o, kill_o, halted_o, stall_cnt_o
  );

endinterface

// File: rtl/urv_redir_tracker.sv
// Tracks how far each taken redirect has propagated into the younger stages.
// Bit k set means the instructions now in stage k+1 are wrong-path.
module urv_redir_tracker #(
  parameter int unsigned g_depth = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               redir_i,
  output logic [g_depth-1:0] bra_o
);

  logic [g_depth-1:0] bra_q, bra_d;

  // Shift the redirect marker forward only when the resolving stage advances.
  always_comb begin
    bra_d = bra_q;
    if (en_i) begin
      bra_d[0] = redir_i;
      for (int k = 1; k < int'(g_depth); k++) begin
        bra_d[k] = bra_q[k-1];
      end
    end
  end

  // Marker register, cleared on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bra_q <= '0;
    end else begin
      bra_q <= bra_d;
    end
  end

  assign bra_o = bra_q;

endmodule

// File: rtl/urv_pipe_ctrl.sv
// Pipeline controller: per-stage stall/kill generation, debug halt FSM and stall counter.
module urv_pipe_ctrl
  import urv_pipe_ctrl_pkg::*;
#(
  parameter int unsigned g_num_stages   = 4,
  parameter int unsigned g_branch_stage = StageExecute,
  parameter int unsigned g_cnt_width    = 32
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  urv_pipe_ctrl_if.slave ctrl_io
);

  localparam int N  = int'(g_num_stages);
  localparam int Br = int'(g_branch_stage);
  localparam int Wb = int'(stage_writeback(g_num_stages));

  pipe_state_e            state_q;
  logic                   halted_q;
  logic [Br-1:0]          bra;
  logic [g_cnt_width-1:0] cnt_q, cnt_d;
  logic                   redir;
  logic                   track_en;
  logic                   drained;
  logic [N-1:0]           stall_base, kill_base;
  logic [N-1:0]           stall, kill;
  logic                   unused_valid_fetch;

  // Fetch validity has no bearing on whether the pipe is drained.
  assign unused_valid_fetch = ctrl_io.stage_valid_i[0];

  urv_redir_tracker #(
    .g_depth (g_branch_stage)
  ) u_tracker (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (track_en),
    .redir_i (redir),
    .bra_o   (bra)
  );

  // State-independent stall and kill: a stage stalls if any older stage stalls; a redirect
  // kills everything from fetch to the resolving stage, markers kill what already advanced.
  always_comb begin
    redir      = ctrl_io.branch_take_i | ctrl_io.flush_i;
    stall_base = '0;
    for (int s = 0; s < N; s++) begin
      stall_base[s] = |(ctrl_io.stall_req_i >> (s + 1));
    end
    kill_base    = '0;
    kill_base[0] = redir;
    for (int s = 1; s <= Br; s++) begin
      kill_base[s] = kill_base[s-1] | bra[s-1];
    end
  end

  // Apply the debug state on top of the base stall/kill.
  always_comb begin
    stall = stall_base;
    kill  = kill_base;
    unique case (state_q)
      StRun:   ;
      StDrain: stall[0] = 1'b1;
      StHalted: begin
        stall = '1;
        kill  = '0;
      end
      default: ;
    endcase
    track_en = ~stall[Br];
    drained  = ~|ctrl_io.stage_valid_i[Wb:1] & ~|bra;
  end

  // Debug halt FSM; halted_q is set on entry so it is high in the first HALTED cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ctrl_io.halt_req_i) state_q <= StDrain;
        end
        StDrain: begin
          if (!ctrl_io.halt_req_i) begin
            state_q <= StRun;
          end else if (drained) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        StHalted: begin
          if (ctrl_io.resume_i) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StRun;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of fetch-stall cycles; halted cycles are not counted.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != StHalted) && stall[0] && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ctrl_io.stall_o     = stall;
  assign ctrl_io.kill_o      = kill;
  assign ctrl_io.halted_o    = halted_q;
  assign ctrl_io.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Scoreboard bench for urv_pipe_ctrl with a behavioural model of redirect kill and halt.
module tb_urv_pipe_ctrl;

  localparam int N      = 4;
  localparam int B      = 2;
  localparam int CW     = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  urv_pipe_ctrl_if #(.NumStages(N), .CntWidth(CW)) bus ();

  urv_pipe_ctrl #(
    .g_num_stages   (N),
    .g_branch_stage (B),
    .g_cnt_width    (CW)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .ctrl_io (bus)
  );

  typedef struct packed {
    logic [N-1:0]  stall;
    logic [N-1:0]  kill;
    logic          halted;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model: mode 0 = running, 1 = draining, 2 = halted. Each pending redirect is an age:
  // the number of stages its wrong-path wavefront has advanced since it was raised.
  int mode  = 0;
  int ages[$];
  int cnt_m = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    logic redir;
    redir = bus.branch_take_i | bus.flush_i;
    e = '0;
    for (int s = 0; s < N; s++) begin
      for (int j = s + 1; j < N; j++) begin
        if (bus.stall_req_i[j]) e.stall[s] = 1'b1;
      end
    end
    if (mode == 1) e.stall[0] = 1'b1;
    if (redir) begin
      for (int s = 0; s <= B; s++) e.kill[s] = 1'b1;
    end
    foreach (ages[i]) begin
      for (int s = ages[i]; s <= B; s++) e.kill[s] = 1'b1;
    end
    if (mode == 2) begin
      e.stall = '1;
      e.kill  = '0;
    end
    e.halted = (mode == 2);
    e.cnt    = CW'(cnt_m);
    return e;
  endfunction

  task automatic model_reset();
    mode  = 0;
    cnt_m = 0;
    ages.delete();
  endtask

  // Advance the model across a clock edge using the inputs that were applied before it.
  task automatic model_edge();
    exp_t e;
    logic redir;
    logic pending;
    int   nq[$];
    if (!rst_n) return;
    e       = model_expect();
    redir   = bus.branch_take_i | bus.flush_i;
    pending = (ages.size() != 0);
    if (!e.stall[B]) begin
      foreach (ages[i]) if (ages[i] < B) nq.push_back(ages[i] + 1);
      if (redir) nq.push_back(1);
      ages = nq;
    end
    if (mode != 2 && e.stall[0] && cnt_m < CntMax) cnt_m++;
    case (mode)
      0: if (bus.halt_req_i) mode = 1;
      1: begin
        if (!bus.halt_req_i) mode = 0;
        else if (bus.stage_valid_i[N-1:1] == '0 && !pending) mode = 2;
      end
      default: if (bus.resume_i) mode = 0;
    endcase
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] vld, input logic bt,
                       input logic fl, input logic hr, input logic rs);
    @(posedge clk);
    #1;
    model_edge();
    bus.stall_req_i   = req;
    bus.stage_valid_i = vld;
    bus.branch_take_i = bt;
    bus.flush_i       = fl;
    bus.halt_req_i    = hr;
    bus.resume_i      = rs;
    sb.push_back(model_expect());
  endtask

  // Called right after cycle(): drops reset mid-cycle, away from any clock edge.
  task automatic async_reset();
    #6;
    rst_n = 1'b0;
    #1;
    check("async_rst_halted", 32'(bus.halted_o), 32'd0);
    check("async_rst_cnt", 32'(bus.stall_cnt_o), 32'd0);
    model_reset();
    sb.delete();
    cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic go_halted();
    cycle('0, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle('0, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle('0, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    check("drain_stall0", 32'(bus.stall_o[0]), 32'd1);
    check("drain_not_halted", 32'(bus.halted_o), 32'd0);
    cycle('0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle('0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    check("halted_first", 32'(bus.halted_o), 32'd1);
    check("halted_stall", 32'(bus.stall_o), 32'hF);
  endtask

  // Monitor: compares every presented output vector against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall_o", 32'(bus.stall_o), 32'(e.stall));
        check("kill_o", 32'(bus.kill_o), 32'(e.kill));
        check("halted_o", 32'(bus.halted_o), 32'(e.halted));
        check("stall_cnt_o", 32'(bus.stall_cnt_o), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          hr_r;
    logic [N-1:0]  req;
    logic [N-1:0]  vld;
    bus.stall_req_i   = '0;
    bus.stage_valid_i = '0;
    bus.branch_take_i = 1'b0;
    bus.flush_i       = 1'b0;
    bus.halt_req_i    = 1'b0;
    bus.resume_i      = 1'b0;

    // Reset: outputs follow inputs with cleared state.
    cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(4'b0100, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;

    // Single branch, no stalls.
    cycle('0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    #3; check("br_c0", 32'(bus.kill_o), 32'h7);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("br_c1", 32'(bus.kill_o), 32'h6);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("br_c2", 32'(bus.kill_o), 32'h4);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("br_c3", 32'(bus.kill_o), 32'h0);

    // Branch and flush together count as one redirect.
    cycle('0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    #3; check("brfl_c0", 32'(bus.kill_o), 32'h7);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("brfl_c1", 32'(bus.kill_o), 32'h6);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("brfl_c2", 32'(bus.kill_o), 32'h4);

    // Writeback stall right after a branch freezes the kill wavefront.
    cycle('0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      check("stl_kill", 32'(bus.kill_o), 32'h6);
      check("stl_stall", 32'(bus.stall_o), 32'h7);
    end
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("stl_after", 32'(bus.kill_o), 32'h4);

    // Halt, drain, halted, resume.
    go_halted();
    cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("resumed", 32'(bus.halted_o), 32'd0);

    // Halt request withdrawn mid-drain, with a redirect tracked during the drain.
    cycle('0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle('0, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle('0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle('0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle('0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle('0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);

    // Counter saturation.
    for (int i = 0; i < 20; i++) cycle(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; check("cnt_sat", 32'(bus.stall_cnt_o), 32'hF);

    // Asynchronous reset while halted.
    go_halted();
    async_reset();
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle('0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    hr_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) hr_r = ~hr_r;
      for (int j = 0; j < N; j++) req[j] = ($urandom_range(4, 0) == 0);
      vld = 4'($urandom_range(15, 0));
      if ($urandom_range(2, 0) == 0) vld[N-1:1] = '0;
      cycle(req, vld, ($urandom_range(4, 0) == 0), ($urandom_range(9, 0) == 0), hr_r,
            ($urandom_range(7, 0) == 0));
      if (i % 200 == 199) async_reset();
    end

    cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
